pmem_loader: RTL and testbench
==============================

// Module: pmem_loader
// PURPOSE
//  Boot-time program loader upstream of the cpu: takes a byte stream (valid/ready), packs
//  big-endian 32-bit words and writes them into cpu program memory from address 0.
//  Holds the cpu in reset until the image is loaded; releases it on success only.
// PARAMETERS
//  ADDR_W  11    program memory address width
//  DEPTH   2048  program memory depth in words; max accepted word count
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       byte stream valid
//  in_data      in   8       byte stream data
//  in_ready     out  1       byte accepted when in_valid & in_ready
//  reload       in   1       1-cycle pulse: restart load from header
//  pmem_we      out  1       program memory write strobe, 1 cycle per word
//  pmem_addr    out  ADDR_W  write address
//  pmem_wdata   out  32      write data
//  cpu_rst      out  1       active-high reset to cpu; 1 until DONE
//  done         out  1       image loaded, cpu running
//  err          out  1       load failed; sticky until reload/reset
// BEHAVIOUR
//  Reset: state=LEN_HI, in_ready=0 for first cycle then 1, pmem_we=0, pmem_addr=0,
//   pmem_wdata=0, cpu_rst=1, done=0, err=0, word/byte counters=0.
//  Stream format: 2-byte big-endian word count N, then N words of 4 bytes, MSB first.
//  States: LEN_HI -> LEN_LO (byte = N[15:8]); LEN_LO -> WORD (N[7:0]);
//   in LEN_LO: N==0 -> DONE; N>DEPTH -> ERR.
//  WORD: bytes shift into packer; on 4th byte, word latched; next cycle pmem_we=1 with
//   pmem_addr=word index, pmem_wdata=word. in_ready stays 1 (no bubble); one write per
//   4 accepted bytes, addresses 0..N-1 strictly ascending.
//  After the write of word N-1 -> DONE (or CSUM if LOADER_CSUM_EN).
//  DONE: cpu_rst=0, done=1, in_ready=0; further bytes ignored (not accepted).
//  ERR: cpu_rst=1, err=1, in_ready=0.
//  reload (any state): next cycle state=LEN_HI, counters/addr=0, cpu_rst=1, done=0,
//   err=0; a partly packed word is discarded, never written. reload wins over a
//   simultaneous byte handshake (that byte is dropped).
//  Byte counter 2 bits, wraps 3->0 per word; word counter ADDR_W+1 bits (holds DEPTH).
//  rst_n assert mid-load: immediate return to reset values, no partial write.
// CONFIGURATION
//  LOADER_CSUM_EN defined: after last word one extra byte expected; must equal 8-bit
//   modular sum of all payload bytes (header excluded). Match -> DONE; mismatch -> ERR.
//   Extra state CSUM.
//  Undefined: no trailing byte; DONE directly after last write; sum logic absent.
// STRUCTURE
//  Shared package: state encoding constants, DEPTH/ADDR_W defaults, header length.
//  One sub-module: word_packer (byte shift register + 2-bit byte counter, word_valid pulse).
// TESTING
//  N=3, bytes F0 00 01 00 / F0 00 01 01 / 18 99 20 00 -> writes addr0=F0000100,
//   addr1=F0000101, addr2=18992000; cpu_rst falls, done=1 one cycle after last write.
//  Header 00 00 -> DONE with zero pmem_we pulses.
//  Header 08 01 (2049) -> err=1, cpu_rst stays 1, in_ready=0, no writes.
//  in_valid toggled randomly mid-word -> same writes as contiguous stream, no duplicates.
//  reload after 2 bytes of word 1 -> no write of word 1; fresh header N=1 writes addr0.
//  LOADER_CSUM_EN: N=1, 01 02 03 04, csum 0A -> done; csum 0B -> err, cpu_rst=1.

Source files
------------

// File: rtl/pmem_loader_pkg.sv
// Shared types and defaults for the boot-time program memory loader.
package pmem_loader_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DEPTH_DEF  = 2048;
  localparam int HDR_BITS   = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_WORD   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;
endpackage

// File: rtl/pmem_loader_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses with the 4th byte.
module pmem_loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_push && (r_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/pmem_loader.sv
// Streams a length-prefixed image into cpu program memory and holds the cpu in reset
// until loaded. Define LOADER_CSUM_EN to require a trailing 8-bit payload checksum.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [31:0]       pmem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  state_t              r_state, w_next;
  logic                r_live;
  logic [7:0]          r_len_hi;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_wcnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                w_hs;
  logic                w_push;
  logic [HDR_BITS-1:0] w_len;
  logic [31:0]         w_word;
  logic                w_word_valid;
`ifdef LOADER_CSUM_EN
  logic [7:0]          r_sum;
`endif

  // reload takes priority, so a byte offered in the same cycle is never taken
  assign w_hs   = in_valid && in_ready && !reload;
  assign w_push = w_hs && (r_state == ST_WORD);
  assign w_len  = {r_len_hi, in_data};

  assign pmem_we    = r_we;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;
  assign cpu_rst    = (r_state != ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);

  pmem_loader_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (reload),
    .i_push       (w_push),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LEN_HI;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (reload) begin
      w_next = ST_LEN_HI;
    end else begin
      case (r_state)
        ST_LEN_HI: if (w_hs) w_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (w_hs) begin
            if (w_len == '0)                      w_next = ST_DONE;
            else if (w_len > HDR_BITS'(DEPTH))    w_next = ST_ERR;
            else                                  w_next = ST_WORD;
          end
        end
        // word count reaches N in the cycle the last write is on the bus
        ST_WORD: begin
          if (r_wcnt == r_len) begin
`ifdef LOADER_CSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_DONE;
`endif
          end
        end
`ifdef LOADER_CSUM_EN
        ST_CSUM: if (w_hs) w_next = (in_data == r_sum) ? ST_DONE : ST_ERR;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_LEN_HI, ST_LEN_LO: in_ready = r_live;
      ST_WORD:              in_ready = r_live && (r_wcnt != r_len);
`ifdef LOADER_CSUM_EN
      ST_CSUM:              in_ready = r_live;
`endif
      default:              in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (reload) begin
      r_len_hi <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_hs && r_state == ST_LEN_HI) r_len_hi <= in_data;
      if (w_hs && r_state == ST_LEN_LO) r_len    <= w_len[ADDR_W:0];
      if (w_word_valid) begin
        r_we    <= 1'b1;
        r_addr  <= r_wcnt[ADDR_W-1:0];
        r_wdata <= w_word;
        r_wcnt  <= r_wcnt + 1'b1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sum <= '0;
    else if (reload) r_sum <= '0;
    else if (w_push) r_sum <= r_sum + in_data;
  end
`endif
endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: expected writes are queued by stimulus, popped by a monitor.
module tb_pmem_loader;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          pmem_we;
  logic [AW-1:0] pmem_addr;
  logic [31:0]   pmem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int               total = 0;
  int               bad = 0;
  int               nwr = 0;
  int               w0;
  bit               gaps = 1'b0;
  logic [7:0]       tb_sum = 8'h00;
  logic [AW+31:0]   expq[$];
  logic [AW+31:0]   mon_e;

  pmem_loader #(.ADDR_W(AW), .DEPTH(2048)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .pmem_we    (pmem_we),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pmem_we === 1'b1) begin
      nwr++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", pmem_addr, pmem_wdata);
      end else begin
        mon_e = expq.pop_front();
        chk("write_addr", 32'(pmem_addr), 32'(mon_e[AW+31:32]));
        chk("write_data", pmem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic header(input logic [15:0] n);
    tb_sum = 8'h00;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    expq.push_back({a, w});
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      tb_sum = tb_sum + w[i*8 +: 8];
    end
  endtask

  task automatic finish_ok();
`ifdef LOADER_CSUM_EN
    send_byte(tb_sum);
    @(negedge clk);
    in_valid = 1'b0;
    chk("done_after_csum", 32'(done), 1);
    chk("cpu_rst_after_csum", 32'(cpu_rst), 0);
`else
    @(negedge clk);
    in_valid = 1'b0;
    chk("last_we", 32'(pmem_we), 1);
    chk("done_during_last_write", 32'(done), 0);
    chk("cpu_rst_during_last_write", 32'(cpu_rst), 1);
    @(negedge clk);
    chk("done_after_last_write", 32'(done), 1);
    chk("cpu_rst_after_last_write", 32'(cpu_rst), 0);
`endif
    chk("in_ready_in_done", 32'(in_ready), 0);
  endtask

  task automatic do_reload(input bit drop);
    @(negedge clk);
    reload   = 1'b1;
    in_valid = drop;
    in_data  = 8'hAA;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("reload_done", 32'(done), 0);
    chk("reload_err", 32'(err), 0);
    chk("reload_cpu_rst", 32'(cpu_rst), 1);
    chk("reload_addr", 32'(pmem_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_we", 32'(pmem_we), 0);
    chk("rst_addr", 32'(pmem_addr), 0);
    chk("rst_wdata", pmem_wdata, 0);
    rst_n = 1'b1;
    chk("rst_in_ready_first", 32'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_first", 32'(in_ready), 1);

    // basic three-word image
    header(16'd3);
    send_word(32'hF0000100, 11'd0);
    send_word(32'hF0000101, 11'd1);
    send_word(32'h18992000, 11'd2);
    finish_ok();

    // bytes offered in DONE are never taken
    w0 = nwr;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    chk("done_ignores_ready", 32'(in_ready), 0);
    chk("done_stays", 32'(done), 1);
    in_valid = 1'b0;
    chk("done_no_writes", 32'(nwr - w0), 0);

    // empty image
    do_reload(1'b0);
    w0 = nwr;
    header(16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("empty_done", 32'(done), 1);
    chk("empty_cpu_rst", 32'(cpu_rst), 0);
    repeat (2) @(negedge clk);
    chk("empty_no_writes", 32'(nwr - w0), 0);

    // oversize header
    do_reload(1'b0);
    w0 = nwr;
    header(16'h0801);
    @(negedge clk);
    in_valid = 1'b0;
    chk("big_err", 32'(err), 1);
    chk("big_cpu_rst", 32'(cpu_rst), 1);
    chk("big_in_ready", 32'(in_ready), 0);
    chk("big_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    chk("big_err_sticky", 32'(err), 1);
    chk("big_no_writes", 32'(nwr - w0), 0);

    // exactly DEPTH words is accepted
    do_reload(1'b0);
    header(16'h0800);
    @(negedge clk);
    in_valid = 1'b0;
    chk("max_len_err", 32'(err), 0);
    chk("max_len_ready", 32'(in_ready), 1);

    // same image with random valid gaps
    do_reload(1'b0);
    gaps = 1'b1;
    header(16'd3);
    send_word(32'hF0000100, 11'd0);
    send_word(32'hF0000101, 11'd1);
    send_word(32'h18992000, 11'd2);
    gaps = 1'b0;
    finish_ok();

    // reload mid-word discards the partial word and the colliding byte
    do_reload(1'b0);
    header(16'd2);
    send_word(32'h11223344, 11'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reload(1'b1);
    header(16'd1);
    send_word(32'h01020304, 11'd0);
    finish_ok();

`ifdef LOADER_CSUM_EN
    do_reload(1'b0);
    header(16'd1);
    send_word(32'h01020304, 11'd0);
    send_byte(8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    chk("csum_bad_err", 32'(err), 1);
    chk("csum_bad_cpu_rst", 32'(cpu_rst), 1);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
